vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 29, vertical front porch, sync and back porch widths in lines
- HS_POL / VS_POL, 0 / 0, asserted level of hsync / vsync
- CLK_DIV, 1, dclk cycles per pixel (1..16)
- COORD_W, 10, width of the coordinate outputs
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- dclk in 1 system clock
- clr_n in 1 reset, asynchronous, active-low
- en in 1 timing advance enable; low freezes the pixel and line counters
- pix_ce out 1 one-dclk pixel strobe, high every CLK_DIV cycles
- hsync out 1 horizontal sync, level set by HS_POL
- vsync out 1 vertical sync, level set by VS_POL
- active out 1 high when the current pixel is visible
- px out COORD_W visible x coordinate; 0 outside the active area
- py out COORD_W visible y coordinate; 0 outside the active area
- line_start out 1 one-dclk pulse on pixel 0 of every line
- frame_start out 1 one-dclk pulse on pixel (0,0) of every frame
- frame_cnt out 16 count of completed frames, wraps modulo 2^16

Function
REQ-003 Derived totals SHALL be H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (521).
REQ-004 The CLK_DIV prescaler SHALL run whenever clr_n is high, independent of en; pix_ce SHALL be high on the last prescaler count, and CLK_DIV=1 SHALL hold pix_ce high permanently.
REQ-005 hc SHALL increment on pix_ce&&en; at hc=H_TOTAL-1 it SHALL wrap to 0 and vc SHALL increment; at vc=V_TOTAL-1 together with that wrap, vc SHALL wrap to 0.
REQ-006 Line order SHALL be active, then front porch, then sync, then back porch: hsync is asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and vsync uses the same rule on vc.
REQ-007 active SHALL equal (hc<H_ACTIVE)&&(vc<V_ACTIVE); px=hc and py=vc when active, otherwise 0.
REQ-008 All outputs SHALL be registered and mutually aligned: outputs describe the counter state one dclk earlier, so latency from a counter change is 1 dclk.
REQ-009 line_start and frame_start SHALL be high only on the dclk when pix_ce&&en and the counter is entering hc=0 (for frame_start, also vc=0); they SHALL never exceed one cycle, even when CLK_DIV>1.
REQ-010 frame_cnt SHALL increment in the same cycle frame_start asserts, and 0xFFFF SHALL wrap to 0x0000.
REQ-011 When en=0, hc, vc, frame_cnt and the level outputs SHALL hold, and line_start and frame_start SHALL be 0.
REQ-012 Parameters SHALL be checked at elaboration: all widths >0, CLK_DIV in 1..16, and H_TOTAL and V_TOTAL each <2^COORD_W; any violation SHALL be a fatal error.

Reset
REQ-013 While clr_n=0: hc=0, vc=0, prescaler=0, frame_cnt=0, pix_ce=0, active=0, px=py=0, line_start=frame_start=0, hsync=!HS_POL, vsync=!VS_POL.
REQ-014 Reset assertion SHALL take effect immediately; deassertion SHALL be synchronous to dclk.
REQ-015 After reset release, the first pix_ce&&en SHALL produce frame_start with pixel (0,0).
REQ-016 Reset asserted mid-frame SHALL discard position, and no partial sync pulse SHALL remain asserted.

Structure
REQ-017 A shared package vga_pkg SHALL hold the default 640x480@60 timing constants and a second set for 800x600; the module takes its parameters from this package.
REQ-018 One sub-module, vga_axis_counter, SHALL be instantiated twice (H and V); it takes parameters ACTIVE, FP, SYNC, BP and POL and has inputs step and outputs count, wrap, sync, in_active.

Verification
REQ-019 Defaults, en=1: exactly 800 dclk between line_start pulses, exactly 416800 dclk between frame_start pulses, and hsync low for 96 pixels beginning at hc=656.
REQ-020 Active-area checks: active is high for exactly 640x480=307200 pixels per frame; the final active pixel shows px=639, py=479; the next cycle shows active=0, px=0, py=0.
REQ-021 CLK_DIV=4: pix_ce high 1 of every 4 dclk, 3200 dclk per line, and line_start exactly 1 dclk wide.
REQ-022 en held low for 1000 dclk mid-line: hc, vc, px and py unchanged, no pulses; on resuming, counting continues from the held value.
REQ-023 clr_n pulsed low at vc=300 with hsync asserted: hsync returns to 1 immediately and frame_cnt=0; after release, the first pix_ce gives frame_start=1 and frame_cnt=1.
REQ-024 HS_POL=1, VS_POL=1 with 800x600 package timing: sync pulses are active-high and frame_cnt reaches 3 after three complete frames.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants: the default 640x480@60 set and an 800x600@60 set.
package vga_pkg;

    // 640x480@60 (25.175 MHz pixel clock), negative syncs
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 29;
    localparam bit VGA640_HS_POL   = 1'b0;
    localparam bit VGA640_VS_POL   = 1'b0;

    // 800x600@60 (40 MHz pixel clock), positive syncs; needs COORD_W >= 11
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_HS_POL   = 1'b1;
    localparam bit SVGA800_VS_POL   = 1'b1;

    // Total length of one axis (pixels per line or lines per frame)
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter plus sync/visible decode.
// count/sync/in_active describe the position being entered on this edge, so the
// parent can register them in the same cycle the counter itself updates.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int W      = 10
) (
    input  logic         dclk,
    input  logic         clr_n,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync,
    output logic         in_active
);

    localparam int           TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);

    logic [W-1:0] cnt_q;

    assign wrap = step && (cnt_q == LAST);

    // Next position: advance on step, wrap to 0 after the last position
    always_comb begin
        count = cnt_q;
        if (step) begin
            count = wrap ? '0 : cnt_q + W'(1);
        end
    end

    assign sync      = ((count >= SYNC_LO) && (count < SYNC_HI)) ? POL : ~POL;
    assign in_active = (count < ACT_END);

    // Position register
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= count;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, H/V counters, registered syncs,
// visible-area coordinates, line/frame strobes and a completed-frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit HS_POL   = VGA640_HS_POL,
    parameter bit VS_POL   = VGA640_VS_POL,
    parameter int CLK_DIV  = 1,
    parameter int COORD_W  = 10
) (
    input  logic               dclk,
    input  logic               clr_n,
    input  logic               en,
    output logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_cnt
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 || COORD_W <= 0) begin : g_bad_width
        $fatal(1, "vga_timing_gen: all timing widths and COORD_W must be positive");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $fatal(1, "vga_timing_gen: CLK_DIV must be in 1..16");
    end
    if (H_TOTAL >= (1 << COORD_W) || V_TOTAL >= (1 << COORD_W)) begin : g_bad_coord
        $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
    end

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]         div_cnt;
    logic               ce_int;
    logic               step;
    logic               started;
    logic               first_step;
    logic               adv;
    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_sync;
    logic               v_sync;
    logic               h_act;
    logic               v_act;
    logic               vis;

    // The first step after reset enters (0,0) instead of advancing, so the
    // first visible strobe is a frame start at the origin.
    assign ce_int     = (div_cnt == DIV_LAST);
    assign step       = ce_int && en;
    assign first_step = step && !started;
    assign adv        = step && started;
    assign vis        = h_act && v_act;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .W      (COORD_W)
    ) u_h (
        .dclk      (dclk),
        .clr_n     (clr_n),
        .step      (adv),
        .count     (h_count),
        .wrap      (h_wrap),
        .sync      (h_sync),
        .in_active (h_act)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .W      (COORD_W)
    ) u_v (
        .dclk      (dclk),
        .clr_n     (clr_n),
        .step      (h_wrap),
        .count     (v_count),
        .wrap      (v_wrap),
        .sync      (v_sync),
        .in_active (v_act)
    );

    // Pixel prescaler, free-running regardless of en
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= ce_int ? 4'd0 : div_cnt + 4'd1;
        end
    end

    // Registered outputs; level outputs only move when the position moves
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            started     <= 1'b0;
            pix_ce      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b0;
            px          <= '0;
            py          <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            pix_ce      <= ce_int;
            line_start  <= first_step || h_wrap;
            frame_start <= first_step || v_wrap;
            if (step) begin
                started <= 1'b1;
                hsync   <= h_sync;
                vsync   <= v_sync;
                active  <= vis;
                px      <= vis ? h_count : '0;
                py      <= vis ? v_count : '0;
                if (first_step || v_wrap) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances on a shrunken raster (CLK_DIV=1 with
// low syncs, CLK_DIV=4 with high syncs), a linear-position reference model feeding
// an expected-output queue, and directed checks on intervals, hold and reset.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int CW = 6;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int DIV_B = 4;

    typedef struct packed {
        logic          pix_ce;
        logic          hsync;
        logic          vsync;
        logic          active;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic          line_start;
        logic          frame_start;
        logic [15:0]   frame_cnt;
    } obs_t;

    logic dclk = 1'b0;
    logic clr_n = 1'b0;
    logic en = 1'b0;

    logic pix_ce_a, hsync_a, vsync_a, active_a, line_start_a, frame_start_a;
    logic [CW-1:0] px_a, py_a;
    logic [15:0] frame_cnt_a;
    logic pix_ce_b, hsync_b, vsync_b, active_b, line_start_b, frame_start_b;
    logic [CW-1:0] px_b, py_b;
    logic [15:0] frame_cnt_b;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .COORD_W(CW)
    ) dut_a (
        .dclk(dclk), .clr_n(clr_n), .en(en), .pix_ce(pix_ce_a),
        .hsync(hsync_a), .vsync(vsync_a), .active(active_a),
        .px(px_a), .py(py_a), .line_start(line_start_a),
        .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(DIV_B), .COORD_W(CW)
    ) dut_b (
        .dclk(dclk), .clr_n(clr_n), .en(en), .pix_ce(pix_ce_b),
        .hsync(hsync_b), .vsync(vsync_b), .active(active_b),
        .px(px_b), .py(py_b), .line_start(line_start_b),
        .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
    );

    always #5 dclk = ~dclk;

    obs_t exp_q_a[$];
    obs_t exp_q_b[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // reference model state, index 0 = dut_a, 1 = dut_b
    int          m_div[2];
    int          m_pos[2];
    bit          m_started[2];
    logic [15:0] m_fc[2];

    // measurement trackers
    int last_ls_a = -1, iv_ls_a = 0, last_fs_a = -1, iv_fs_a = 0;
    int last_ls_b = -1, iv_ls_b = 0, ls_b_wide = 0, pce_b = 0;
    int act_run = 0, act_frame = 0, hs_run = 0, hs_low = 0, hs_start_off = 0;
    int hsb_high = 0, vsb_high = 0, pulses = 0;
    bit prev_ls_b = 1'b0, prev_hs = 1'b1, prev_act = 1'b0, seen_last = 1'b0;
    logic [CW-1:0] prev_px = '0, prev_py = '0, last_px = '0, last_py = '0, after_px = '0, after_py = '0;
    logic after_act = 1'b0;

    // Advance the model across one dclk edge and return the outputs expected after it
    function automatic obs_t model_edge(input int k);
        obs_t o;
        int   div;
        logic pol;
        bit   ce;
        bit   stepped;
        int   x;
        int   y;
        div = (k == 0) ? 1 : DIV_B;
        pol = (k == 0) ? 1'b0 : 1'b1;
        o = '0;
        o.hsync = ~pol;
        o.vsync = ~pol;
        if (!clr_n) begin
            m_div[k] = 0;
            m_pos[k] = 0;
            m_started[k] = 1'b0;
            m_fc[k] = '0;
            return o;
        end
        ce = (m_div[k] == div - 1);
        m_div[k] = (m_div[k] + 1) % div;
        stepped = ce && en;
        if (stepped) begin
            if (m_started[k]) m_pos[k] = (m_pos[k] + 1) % FRAME;
            else m_started[k] = 1'b1;
            if (m_pos[k] == 0) m_fc[k] = m_fc[k] + 16'd1;
        end
        o.pix_ce = ce;
        o.frame_cnt = m_fc[k];
        if (m_started[k]) begin
            x = m_pos[k] % HT;
            y = m_pos[k] / HT;
            o.hsync = (x >= HA + HF && x < HA + HF + HS) ? pol : ~pol;
            o.vsync = (y >= VA + VF && y < VA + VF + VS) ? pol : ~pol;
            o.active = (x < HA) && (y < VA);
            o.px = o.active ? CW'(x) : '0;
            o.py = o.active ? CW'(y) : '0;
            o.line_start = stepped && (x == 0);
            o.frame_start = stepped && (m_pos[k] == 0);
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One dclk: queue expectations, clock, then compare on the falling edge
    task automatic tick();
        obs_t oa, ob, ea, eb;
        exp_q_a.push_back(model_edge(0));
        exp_q_b.push_back(model_edge(1));
        @(posedge dclk);
        @(negedge dclk);
        cyc++;
        oa = {pix_ce_a, hsync_a, vsync_a, active_a, px_a, py_a, line_start_a, frame_start_a, frame_cnt_a};
        ob = {pix_ce_b, hsync_b, vsync_b, active_b, px_b, py_b, line_start_b, frame_start_b, frame_cnt_b};
        ea = exp_q_a.pop_front();
        eb = exp_q_b.pop_front();
        vectors += 2;
        assert (oa === ea) else begin
            miscompares++;
            $error("FAIL stream_a cyc %0d: observed %h expected %h", cyc, oa, ea);
        end
        assert (ob === eb) else begin
            miscompares++;
            $error("FAIL stream_b cyc %0d: observed %h expected %h", cyc, ob, eb);
        end
        if (line_start_a) begin
            if (last_ls_a >= 0) iv_ls_a = cyc - last_ls_a;
            last_ls_a = cyc;
        end
        if (frame_start_a) begin
            if (last_fs_a >= 0) iv_fs_a = cyc - last_fs_a;
            last_fs_a = cyc;
            act_frame = act_run;
            act_run = 0;
        end
        if (active_a) act_run++;
        if (line_start_b) begin
            if (last_ls_b >= 0) iv_ls_b = cyc - last_ls_b;
            last_ls_b = cyc;
        end
        if (line_start_b && prev_ls_b) ls_b_wide++;
        prev_ls_b = line_start_b;
        if (pix_ce_b) pce_b++;
        if (!hsync_a && prev_hs && last_ls_a >= 0) hs_start_off = cyc - last_ls_a;
        if (!hsync_a) hs_run++;
        else if (hs_run > 0) begin
            hs_low = hs_run;
            hs_run = 0;
        end
        prev_hs = hsync_a;
        if (prev_act && !active_a && int'(prev_py) == VA - 1) begin
            seen_last = 1'b1;
            last_px = prev_px;
            last_py = prev_py;
            after_act = active_a;
            after_px = px_a;
            after_py = py_a;
        end
        prev_act = active_a;
        prev_px = px_a;
        prev_py = py_a;
        if (line_start_a || frame_start_a || line_start_b || frame_start_b) pulses++;
        if (hsync_b) hsb_high++;
        if (vsync_b) vsb_high++;
    endtask

    initial begin
        int n;

        // reset held
        repeat (3) tick();
        check("reset_hsync_a", 32'(hsync_a), 32'd1);
        check("reset_hsync_b", 32'(hsync_b), 32'd0);
        check("reset_pix_ce_a", 32'(pix_ce_a), 32'd0);
        check("reset_frame_cnt_a", 32'(frame_cnt_a), 32'd0);

        // free run, several frames of dut_a and two of dut_b
        clr_n = 1'b1;
        en = 1'b1;
        tick();
        check("first_frame_start_a", 32'(frame_start_a), 32'd1);
        check("first_px_a", 32'(px_a), 32'd0);
        check("first_frame_cnt_a", 32'(frame_cnt_a), 32'd1);
        pce_b = 0;
        repeat (2120) tick();
        check("line_interval_a", 32'(iv_ls_a), 32'(HT));
        check("frame_interval_a", 32'(iv_fs_a), 32'(FRAME));
        check("hsync_low_width_a", 32'(hs_low), 32'(HS));
        check("hsync_start_offset_a", 32'(hs_start_off), 32'(HA + HF));
        check("active_pixels_a", 32'(act_frame), 32'(HA * VA));
        check("last_active_seen", 32'(seen_last), 32'd1);
        check("last_active_px", 32'(last_px), 32'(HA - 1));
        check("last_active_py", 32'(last_py), 32'(VA - 1));
        check("after_last_active", 32'(after_act), 32'd0);
        check("after_last_px", 32'(after_px), 32'd0);
        check("after_last_py", 32'(after_py), 32'd0);
        check("pix_ce_rate_b", 32'(pce_b), 32'(2120 / DIV_B));
        check("line_interval_b", 32'(iv_ls_b), 32'(HT * DIV_B));
        check("line_start_width_b", 32'(ls_b_wide), 32'd0);

        // en low for 1000 dclk at (4,1)
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start_a && n < FRAME + 4);
        check("wait_frame_start_a", 32'(frame_start_a), 32'd1);
        repeat (HT + 4) tick();
        en = 1'b0;
        pulses = 0;
        repeat (1000) tick();
        check("hold_px_a", 32'(px_a), 32'd4);
        check("hold_py_a", 32'(py_a), 32'd1);
        check("hold_no_pulses", 32'(pulses), 32'd0);
        en = 1'b1;
        tick();
        check("resume_px_a", 32'(px_a), 32'd5);
        check("resume_py_a", 32'(py_a), 32'd1);

        // asynchronous reset in the middle of an hsync pulse
        n = 0;
        do begin
            tick();
            n++;
        end while (hsync_a !== 1'b0 && n < 2 * HT);
        check("hsync_low_before_reset", 32'(hsync_a), 32'd0);
        #2;
        clr_n = 1'b0;
        #1;
        check("async_reset_hsync_a", 32'(hsync_a), 32'd1);
        check("async_reset_frame_cnt_a", 32'(frame_cnt_a), 32'd0);
        check("async_reset_px_a", 32'(px_a), 32'd0);
        check("async_reset_hsync_b", 32'(hsync_b), 32'd0);
        repeat (3) tick();
        clr_n = 1'b1;
        hsb_high = 0;
        vsb_high = 0;
        tick();
        check("post_reset_frame_start_a", 32'(frame_start_a), 32'd1);
        check("post_reset_frame_cnt_a", 32'(frame_cnt_a), 32'd1);

        // three full frames of dut_b with active-high syncs
        repeat (3 * FRAME * DIV_B - 1) tick();
        check("frame_cnt_b_3frames", 32'(frame_cnt_b), 32'd3);
        check("frame_cnt_a_3frames", 32'(frame_cnt_a), 32'd12);
        check("hsync_high_b", 32'(hsb_high), 32'(3 * VT * HS * DIV_B));
        check("vsync_high_b", 32'(vsb_high), 32'(3 * VS * HT * DIV_B));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
